// File: rtl/pet_mood.sv
// Pet mood FSM: registered stats, hysteresis, 1 s prescaler, death timer.
// Optional PET_SLEEP_EN adds a SLEEP mood driven by critical energy.
module pet_mood #(
    parameter int unsigned TICK_DIV   = 27_000_000,
    parameter int unsigned WARN_LVL   = 10,
    parameter int unsigned CRIT_LVL   = 14,
    parameter int unsigned HYST       = 2,
    parameter int unsigned DEATH_SECS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hunger,
    input  logic [3:0] happiness,
    input  logic [3:0] health,
    input  logic [3:0] hygiene,
    input  logic [3:0] energy,
    input  logic       revive,
    output logic [2:0] mood,
    output logic       mood_chg,
    output logic       alarm,
    output logic       dead,
    output logic [7:0] crit_secs
);

    typedef enum logic [2:0] {
        HAPPY  = 3'd0,
        HUNGRY = 3'd1,
        SICK   = 3'd2,
        DIRTY  = 3'd3,
        TIRED  = 3'd4,
        SAD    = 3'd5,
        SLEEP  = 3'd6,
        DEAD   = 3'd7
    } mood_t;

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TOP  = PW'(TICK_DIV - 1);
    localparam logic [3:0]    WARN = 4'(WARN_LVL);
    localparam logic [3:0]    CRIT = 4'(CRIT_LVL);
    localparam logic [3:0]    EXIT = 4'(WARN_LVL - HYST);
    localparam logic [7:0]    DSEC = 8'(DEATH_SECS);

    logic [3:0]    hunger_q, happy_q, health_q, hyg_q, energy_q;
    mood_t         state, nxt;
    logic [PW-1:0] cnt;
    logic          tick;
    logic          cand_ok;
    mood_t         cand;
    logic [3:0]    cand_val, cur_val;
    logic          any_crit, alarm_d;
    logic [7:0]    crit_d;

    assign tick = (cnt == TOP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hunger_q <= '0;
            happy_q  <= '0;
            health_q <= '0;
            hyg_q    <= '0;
            energy_q <= '0;
        end else begin
            hunger_q <= hunger;
            happy_q  <= happiness;
            health_q <= health;
            hyg_q    <= hygiene;
            energy_q <= energy;
        end
    end

    // Highest stat wins; checked in tie-priority order so only a strictly
    // larger value can displace an earlier candidate.
    always_comb begin
        cand_ok  = 1'b0;
        cand     = HAPPY;
        cand_val = '0;
        if (health_q >= WARN) begin
            cand_ok = 1'b1; cand = SICK; cand_val = health_q;
        end
        if (hunger_q >= WARN && (!cand_ok || hunger_q > cand_val)) begin
            cand_ok = 1'b1; cand = HUNGRY; cand_val = hunger_q;
        end
        if (energy_q >= WARN && (!cand_ok || energy_q > cand_val)) begin
            cand_ok = 1'b1; cand = TIRED; cand_val = energy_q;
        end
        if (hyg_q >= WARN && (!cand_ok || hyg_q > cand_val)) begin
            cand_ok = 1'b1; cand = DIRTY; cand_val = hyg_q;
        end
        if (happy_q >= WARN && (!cand_ok || happy_q > cand_val)) begin
            cand_ok = 1'b1; cand = SAD; cand_val = happy_q;
        end
    end

    always_comb begin
        case (state)
            HUNGRY:  cur_val = hunger_q;
            SICK:    cur_val = health_q;
            DIRTY:   cur_val = hyg_q;
            TIRED:   cur_val = energy_q;
            SAD:     cur_val = happy_q;
            default: cur_val = '0;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            DEAD: begin
                if (revive) nxt = HAPPY;
            end
            HAPPY: begin
                if (cand_ok) nxt = cand;
            end
            SLEEP: begin
                if (energy_q <= EXIT) nxt = cand_ok ? cand : HAPPY;
            end
            default: begin
                if (cand_ok && cand_val > cur_val)
                    nxt = cand;
                else if (cur_val <= EXIT)
                    nxt = cand_ok ? cand : HAPPY;
            end
        endcase
`ifdef PET_SLEEP_EN
        if (state != DEAD && energy_q >= CRIT) nxt = SLEEP;
`endif
        if (state != DEAD && crit_secs >= DSEC) nxt = DEAD;
    end

    always_comb begin
        any_crit = (health_q >= CRIT) || (hunger_q >= CRIT)
                || (hyg_q >= CRIT) || (happy_q >= CRIT);
`ifdef PET_SLEEP_EN
        if (energy_q >= CRIT && nxt != SLEEP) any_crit = 1'b1;
`else
        if (energy_q >= CRIT) any_crit = 1'b1;
`endif
        alarm_d = any_crit && (nxt != DEAD);
    end

    always_comb begin
        crit_d = crit_secs;
        if (state == DEAD) begin
            if (revive) crit_d = '0;
        end else if (health_q < CRIT) begin
            crit_d = '0;
        end else if (tick && crit_secs != 8'hff) begin
            crit_d = crit_secs + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HAPPY;
            mood_chg  <= 1'b0;
            alarm     <= 1'b0;
            crit_secs <= '0;
            cnt       <= '0;
        end else begin
            state     <= nxt;
            mood_chg  <= (nxt != state);
            alarm     <= alarm_d;
            crit_secs <= crit_d;
            if ((state == DEAD && revive) || tick)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    assign mood = state;
    assign dead = (state == DEAD);

endmodule

// File: tb/tb_pet_mood.sv
// Scoreboard bench for pet_mood: mood changes queued by stimulus,
// popped by a monitor on every mood_chg pulse.
module tb_pet_mood;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] hunger, happiness, health, hygiene, energy;
    logic       revive;
    logic [2:0] mood;
    logic       mood_chg, alarm, dead;
    logic [7:0] crit_secs;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];

    pet_mood #(
        .TICK_DIV(4),
        .DEATH_SECS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hunger(hunger),
        .happiness(happiness),
        .health(health),
        .hygiene(hygiene),
        .energy(energy),
        .revive(revive),
        .mood(mood),
        .mood_chg(mood_chg),
        .alarm(alarm),
        .dead(dead),
        .crit_secs(crit_secs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_crit(input int v);
        int k;
        k = 0;
        while (crit_secs != 8'(v) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("crit_reach_%0d", v), crit_secs, v);
    endtask

    task automatic wait_dead();
        int k;
        k = 0;
        while (!dead && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("dead_reach", dead, 1);
    endtask

    // Monitor: every mood_chg pulse must match the next queued mood.
    always @(negedge clk) begin
        if (!reset && mood_chg) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got mood %0d with no change queued", mood);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (mood != e) begin
                    n_fail++;
                    $display("FAIL sb_mood: got %0d expected %0d", mood, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        {hunger, happiness, health, hygiene, energy} = '0;
        revive = 1'b0;
        #1;
        check("rst_mood", mood, 0);
        check("rst_alarm", alarm, 0);
        check("rst_dead", dead, 0);
        check("rst_crit", crit_secs, 0);
        cyc(2);
        reset = 1'b0;
        cyc(3);

        // 1: enter HUNGRY at 10, hold at 9, leave at 8
        exp_q.push_back(3'd1);
        hunger = 4'd10;
        cyc(1);
        check("t1_latency", mood, 0);
        cyc(1);
        check("t1_hungry", mood, 1);
        check("t1_pulse", mood_chg, 1);
        cyc(1);
        check("t1_pulse_off", mood_chg, 0);
        hunger = 4'd9;
        cyc(3);
        check("t1_hyst", mood, 1);
        exp_q.push_back(3'd0);
        hunger = 4'd8;
        cyc(2);
        check("t1_exit", mood, 0);

        // 2: tie does not preempt, strictly higher does
        exp_q.push_back(3'd1);
        hunger = 4'd11;
        cyc(2);
        check("t2_hungry", mood, 1);
        health = 4'd11;
        cyc(3);
        check("t2_tie", mood, 1);
        exp_q.push_back(3'd2);
        health = 4'd12;
        cyc(2);
        check("t2_sick", mood, 2);

        // 3: critical health counts up to death, revive
        health = 4'd14;
        cyc(2);
        check("t3_alarm", alarm, 1);
        check("t3_still_sick", mood, 2);
        exp_q.push_back(3'd7);
        wait_crit(1);
        wait_crit(2);
        wait_crit(3);
        check("t3_not_yet", dead, 0);
        cyc(1);
        check("t3_mood_dead", mood, 7);
        check("t3_dead", dead, 1);
        check("t3_alarm_dead", alarm, 0);
        health = 4'd0;
        hunger = 4'd0;
        cyc(4);
        check("t3_absorb", mood, 7);
        check("t3_crit_hold", crit_secs, 3);
        exp_q.push_back(3'd0);
        revive = 1'b1;
        cyc(1);
        revive = 1'b0;
        check("t3_revive_mood", mood, 0);
        check("t3_revive_dead", dead, 0);
        check("t3_revive_crit", crit_secs, 0);

        // 4: critical for two ticks then recovery
        exp_q.push_back(3'd2);
        health = 4'd12;
        cyc(2);
        check("t4_sick", mood, 2);
        health = 4'd14;
        wait_crit(1);
        wait_crit(2);
        health = 4'd13;
        cyc(2);
        check("t4_crit_clr", crit_secs, 0);
        check("t4_alarm_clr", alarm, 0);
        cyc(12);
        check("t4_alive", dead, 0);
        check("t4_stay_sick", mood, 2);

        // 5: reset while DEAD and mid-prescale
        exp_q.push_back(3'd7);
        health = 4'd14;
        wait_dead();
        cyc(1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_mood", mood, 0);
        check("t5_dead", dead, 0);
        check("t5_crit", crit_secs, 0);
        check("t5_alarm", alarm, 0);
        check("t5_chg", mood_chg, 0);
        {hunger, happiness, health, hygiene, energy} = '0;
        @(negedge clk);
        reset = 1'b0;
        cyc(5);
        check("t5_post_mood", mood, 0);
        check("t5_post_alarm", alarm, 0);
        check("t5_post_crit", crit_secs, 0);

        // 6: critical energy
`ifdef PET_SLEEP_EN
        exp_q.push_back(3'd6);
        energy = 4'd14;
        cyc(2);
        check("t6_mood", mood, 6);
        check("t6_alarm", alarm, 0);
`else
        exp_q.push_back(3'd4);
        energy = 4'd14;
        cyc(2);
        check("t6_mood", mood, 4);
        check("t6_alarm", alarm, 1);
`endif
        exp_q.push_back(3'd0);
        energy = 4'd0;
        cyc(2);
        check("t6_exit", mood, 0);
        cyc(4);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
